alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execution-side consumer of the 4-bit ALU operation code produced by the ALU control decoder in the MIPS datapath.
- Performs single-cycle ops (add, sub, and, or, slt, sll) in one clock.
- Performs signed mult/div iteratively over multiple cycles and holds the results in HI/LO registers.
- Uses a start/busy/done handshake so the pipeline control can stall while mult/div is in flight.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- SHW, 5, shift-amount width; equals clog2(WIDTH).

Ports:
- clk     input   1      system clock, rising edge
- rst     input   1      synchronous, active-high reset
- start   input   1      request; sampled only when busy=0
- op      input   4      ALU operation code: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sll, 6 mult, 7 div
- a       input   WIDTH  operand A (rs)
- b       input   WIDTH  operand B (rt)
- shamt   input   SHW    shift amount for sll
- result  output  WIDTH  registered result
- zero    output  1      registered, (result == 0)
- hi      output  WIDTH  HI register: mult upper half / div remainder
- lo      output  WIDTH  LO register: mult lower half / div quotient
- busy    output  1      mult/div in progress
- done    output  1      one-cycle pulse when an accepted op completes

Behaviour:
- Reset: rst=1 at a rising edge clears result, hi, lo, busy and done to 0; zero goes to 1; FSM returns to IDLE. Reset mid-mult/div aborts the operation with no done pulse.
- FSM states: IDLE, ITER, FIX.
- IDLE with start=1 and op in 0..5:
  - At that edge (E0): result <= op result, zero updated, done <= 1. Latency 1 cycle; busy stays 0.
  - add/sub: modulo 2^WIDTH, no overflow trap.
  - slt: signed compare, result is 1 or 0.
  - sll: result = b << shamt.
- IDLE with start=1 and op 8..15: result <= 0, zero <= 1, done <= 1. No error signal.
- IDLE with start=1 and op 6/7:
  - At E0: latch |a|, |b| and the sign info; load the iteration counter with WIDTH; state -> ITER; busy <= 1.
  - ITER: one shift-add (mult) or restoring shift-subtract (div) step per edge, E1..E32. Counter decrements; at zero, state -> FIX.
  - FIX at E33: apply sign correction and write hi/lo; result <= lo; zero updated; busy <= 0; done <= 1; state -> IDLE.
  - Net latency: done is high in the cycle after E33. busy is high for exactly 33 cycles.
- Sign rules:
  - mult: {hi,lo} is the signed 64-bit product.
  - div: quotient truncates toward zero; remainder takes the sign of the dividend.
- Div by zero: lo = all ones, hi = a. Normal latency, no trap.
- Overflow case (-2^31 / -1): lo = 0x80000000, hi = 0.
- start while busy=1 is ignored; the in-flight op is unaffected.
- done is a pulse: it clears on the next edge unless a new single-cycle op is accepted on that edge. Back-to-back single-cycle ops therefore give done=1 every cycle.
- hi/lo change only in FIX. result/zero hold their value until the next completion.

Decomposition:
- Shared package alu_pkg:
  - Op code constants ALU_ADD=0 .. ALU_DIV=7.
  - FSM state encoding.
  - WIDTH default.
  - Shared with the ALU control decoder so both ends agree on the codes.
- Sub-module alu_muldiv_core:
  - Owns the iteration counter, partial remainder/product registers and the sign fix.
  - Has its own start/done handshake.
- The top level keeps the single-cycle datapath, the output registers and the busy/done muxing.

Test Plan:
- Reset then idle: rst high 2 cycles -> result=0, hi=lo=0, busy=0, done=0, zero=1.
- Single-cycle ops:
  - add a=0xFFFFFFFF, b=1 -> next cycle result=0, zero=1, done=1.
  - slt a=0xFFFFFFFE (-2), b=1 -> result=1.
  - sll b=0x1, shamt=31 -> result=0x80000000.
- mult a=-3, b=7:
  - start -> busy=1 for 33 cycles, done pulses after E33.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB, result=lo.
- div a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- div a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
- div a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- Busy and reset interactions:
  - start add issued at cycle 10 of a mult -> ignored; mult results are correct.
  - rst at cycle 15 of a div -> busy=0 next cycle, no done, hi/lo=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, FSM encoding and default width
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_MULT = 4'd6;
    localparam logic [3:0] ALU_DIV  = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/alu_muldiv_core.sv
// rtl/alu_muldiv_core.sv - iterative signed multiply / restoring divide engine
module alu_muldiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             fin,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_t        state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] dvs;
    logic             div_q, a_neg, b_neg, b_zero;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   add_sum, shifted, diff, part, acc_step;
    logic [WIDTH-1:0] mq_step;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0] q_s, r_s;

    assign a_abs = a[WIDTH-1] ? -a : a;
    assign b_abs = b[WIDTH-1] ? -b : b;

    // One step: mult shifts {acc,mq} right after a conditional add;
    // div shifts the remainder left and keeps the difference when non-negative.
    always_comb begin
        add_sum  = acc + {1'b0, dvs};
        shifted  = {acc[WIDTH-1:0], mq[WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        part     = mq[0] ? add_sum : acc;
        acc_step = {1'b0, part[WIDTH:1]};
        mq_step  = {part[0], mq[WIDTH-1:1]};
        if (div_q) begin
            if (!diff[WIDTH]) begin
                acc_step = diff;
                mq_step  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = shifted;
                mq_step  = {mq[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod   = {acc[WIDTH-1:0], mq};
        prod_s = (a_neg ^ b_neg) ? -prod : prod;
        q_s    = (a_neg ^ b_neg) ? -mq : mq;
        r_s    = a_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        if (div_q) begin
            hi = r_s;
            lo = b_zero ? '1 : q_s;
        end else begin
            hi = prod_s[2*WIDTH-1:WIDTH];
            lo = prod_s[WIDTH-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ITER;
            S_ITER:  if (cnt == CW'(1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mq     <= '0;
            dvs    <= '0;
            div_q  <= 1'b0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            b_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                div_q  <= is_div;
                a_neg  <= a[WIDTH-1];
                b_neg  <= b[WIDTH-1];
                b_zero <= (b == '0);
                acc    <= '0;
                mq     <= is_div ? a_abs : b_abs;
                dvs    <= is_div ? b_abs : a_abs;
                cnt    <= CW'(WIDTH);
            end else if (state == S_ITER) begin
                acc <= acc_step;
                mq  <= mq_step;
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign fin  = (state == S_FIX);

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - MIPS ALU execute stage: single-cycle ops plus multi-cycle mult/div
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    logic             accept, is_md;
    logic             md_fin;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [WIDTH-1:0] sc_result;

    assign accept = start && !busy;
    assign is_md  = (op == ALU_MULT) || (op == ALU_DIV);

    alu_muldiv_core #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_md),
        .is_div (op == ALU_DIV),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .fin    (md_fin),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    // Undefined op codes complete normally with a zero result.
    always_comb begin
        sc_result = '0;
        case (op)
            ALU_ADD: sc_result = a + b;
            ALU_SUB: sc_result = a - b;
            ALU_AND: sc_result = a & b;
            ALU_OR:  sc_result = a | b;
            ALU_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL: sc_result = b << shamt;
            default: sc_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b1;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (md_fin) begin
                hi     <= md_hi;
                lo     <= md_lo;
                result <= md_lo;
                zero   <= (md_lo == '0);
                done   <= 1'b1;
            end else if (accept && !is_md) begin
                result <= sc_result;
                zero   <= (sc_result == '0);
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  shamt;
    logic [31:0] result, hi, lo;
    logic        zero, busy, done;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_result, exp_hi, exp_lo;

    alu_exec_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .shamt(shamt), .result(result), .zero(zero), .hi(hi), .lo(lo),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_single(input logic [3:0] o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [4:0] s);
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            4'd0:    return 32'(sx + sy);
            4'd1:    return 32'(sx - sy);
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd4:    return (sx < sy) ? 32'd1 : 32'd0;
            4'd5:    return 32'(longint'(y) * (longint'(1) << s));
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_md(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] rh, output logic [31:0] rl);
        longint sx, sy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == 4'd6) begin
            p  = sx * sy;
            rh = p[63:32];
            rl = p[31:0];
        end else if (sy == 0) begin
            rh = x;
            rl = 32'hFFFF_FFFF;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            rl = q[31:0];
            rh = r[31:0];
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_result"}, result, exp_result);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_result == 32'd0});
    endtask

    task automatic single(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] s);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; shamt = s;
        @(negedge clk);
        start = 1'b0;
        exp_result = ref_single(o, x, y, s);
        check_outputs("single");
        check("single_done", {31'd0, done}, 32'd1);
        check("single_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("single_done_clear", {31'd0, done}, 32'd0);
    endtask

    // poke: busy cycle at which an add is requested; rst_at: busy cycle at which reset fires
    task automatic md(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                      input int poke, input int rst_at);
        int   n;
        logic saw_done, aborted;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        n = 0; saw_done = 1'b0; aborted = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            if (done) saw_done = 1'b1;
            n++;
            start = (n == poke);
            if (start) begin
                op = 4'd0; a = $urandom; b = $urandom;
            end
            rst = (n == rst_at);
            @(negedge clk);
            start = 1'b0;
            if (rst) begin
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            exp_result = 32'd0; exp_hi = 32'd0; exp_lo = 32'd0;
            check("abort_busy", {31'd0, busy}, 32'd0);
            check("abort_done", {31'd0, done}, 32'd0);
            check("abort_hi", hi, exp_hi);
            check("abort_lo", lo, exp_lo);
            check_outputs("abort");
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end else begin
            ref_md(o, x, y, exp_hi, exp_lo);
            exp_result = exp_lo;
            check("md_busy_cycles", n, 33);
            check("md_early_done", {31'd0, saw_done}, 32'd0);
            check("md_done", {31'd0, done}, 32'd1);
            check("md_hi", hi, exp_hi);
            check("md_lo", lo, exp_lo);
            check_outputs("md");
            @(negedge clk);
            check("md_done_clear", {31'd0, done}, 32'd0);
        end
    endtask

    // Back-to-back single-cycle ops: done must stay high on every cycle of the burst.
    task automatic burst(input int cnt);
        logic [3:0]  o;
        logic [31:0] x, y;
        logic [4:0]  s;
        @(negedge clk);
        for (int i = 0; i <= cnt; i++) begin
            if (i > 0) begin
                exp_result = ref_single(o, x, y, s);
                check_outputs("burst");
                check("burst_done", {31'd0, done}, 32'd1);
                check("burst_hi", hi, exp_hi);
            end
            if (i < cnt) begin
                o = 4'($urandom_range(0, 15));
                if (o == 4'd6 || o == 4'd7) o = o + 4'd4;
                x = $urandom; y = $urandom; s = 5'($urandom);
                if ($urandom_range(0, 3) == 0) y = -x;
                start = 1'b1; op = o; a = x; b = y; shamt = s;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("burst_done_clear", {31'd0, done}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; shamt = 5'd0;
        exp_result = 32'd0; exp_hi = 32'd0; exp_lo = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_result", result, 32'd0);
        check("reset_zero", {31'd0, zero}, 32'd1);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        single(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd0);
        single(4'd4, 32'hFFFF_FFFE, 32'd1, 5'd0);
        single(4'd5, 32'd7, 32'd1, 5'd31);
        single(4'd9, 32'd3, 32'd4, 5'd0);

        md(4'd6, -32'sd3, 32'd7, 0, 0);
        md(4'd7, -32'sd7, 32'd2, 0, 0);
        md(4'd7, 32'd5, 32'd0, 0, 0);
        md(4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        md(4'd6, 32'h8000_0000, 32'h8000_0000, 0, 0);
        md(4'd6, $urandom, $urandom, 10, 0);
        md(4'd7, $urandom, 32'd3, 0, 15);

        burst(40);

        for (int i = 0; i < 16; i++) begin
            md(($urandom_range(0, 1) == 0) ? 4'd6 : 4'd7, pick(), pick(), 0, 0);
            if (i % 4 == 0) burst(5);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
